arb4_client: RTL and testbench
==============================

# arb4_client

Synchronous requester front-end for the 4-input mutex arbiter. It turns per-channel start pulses into level-held `req` lines that drive the arbiter's X inputs. It also brings the arbiter's Y grants into the clock domain through synchronizers. Each channel holds its grant for a programmed number of cycles, then completes a 4-phase release handshake. The block sits directly upstream of the arbiter and consumes its grant outputs. It also monitors mutual exclusion on the synchronized grants.

## Interface
- `NUM_REQ`, 4, number of channels; fixed at 4 to match the arbiter.
- `SYNC_STAGES`, 2, flip-flop depth of each grant synchronizer; legal values are 2 or more.
- `HOLD_W`, 8, width of the hold-length field.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  NUM_REQ  per-channel request pulse; sampled only when that channel is IDLE.
- `hold_len`  in  HOLD_W  grant hold length, captured by a channel on the edge that accepts its start.
- `req`  out  NUM_REQ  registered request to arbiter inputs X3..X0 (bit i drives Xi).
- `grant`  in  NUM_REQ  asynchronous grant from arbiter outputs Y3..Y0; synchronized internally.
- `busy`  out  NUM_REQ  channel is not IDLE.
- `active`  out  NUM_REQ  channel is in HOLD and owns the resource.
- `done`  out  NUM_REQ  one-cycle pulse when the channel returns to IDLE.
- `mutex_err`  out  1  sticky flag: more than one synchronized grant was seen high in the same cycle.

## Operation
- Per-channel grant synchronizer: `gsync[i]` is `grant[i]` delayed through SYNC_STAGES flops. The FSM never reads raw `grant`.
- Each channel has an independent FSM with a HOLD_W-bit down-counter and a captured length register.
  - IDLE: `req`=0. If `start[i]`=1, capture `hold_len` into the length register and go to REQ.
  - REQ: `req`=1. Wait until `gsync[i]`=1, then go to HOLD and load the counter with max(len,1).
  - HOLD: `req`=1, `active`=1. Decrement the counter each cycle. When the counter reaches 1, go to RELEASE.
  - RELEASE: `req`=0. Wait until `gsync[i]`=0, then go to IDLE and pulse `done[i]` for 1 cycle.
- `start[i]` in any state other than IDLE is ignored (no queuing).
- `hold_len`=0 is treated as 1 (HOLD lasts exactly one cycle). `hold_len`=2^HOLD_W−1 gives a HOLD of 255 cycles with no wrap-around.
- `busy[i]` = (state != IDLE). `active[i]` = (state == HOLD). Both are registered state decodes.
- `mutex_err` sets on any cycle where the popcount of `gsync` is greater than 1. It stays set until `rst`.
- A channel in REQ waits indefinitely; the block has no timeout. Contention is resolved solely by the arbiter.
- Simultaneous starts on several channels: every channel enters REQ on the same edge. Grants are then serialized by the arbiter, and each loser stays in REQ until its grant arrives.
- Reset mid-operation: on the `rst` edge, all FSMs go to IDLE and the following registers clear to 0: `req`, `busy`, `active`, `done`, `mutex_err`, the counters and the synchronizers. Any grant held by the arbiter is released because `req` drops. No `done` pulse is generated for an aborted channel.

## Timing
- Reset values: `req`=0, `busy`=0, `active`=0, `done`=0, `mutex_err`=0; all FSMs in IDLE.
- Uncontested arbiter with zero delay, SYNC_STAGES=2, edge E0 samples `start[i]`=1:
  - `req[i]` and `busy[i]` go high after E0.
  - `gsync[i]`=1 after E2.
  - HOLD is entered at E3, with `active[i]`=1 from E3.
  - RELEASE is entered at E3+L, where L = max(len,1); `req[i]` drops there.
  - `gsync[i]`=0 after E5+L.
  - IDLE is entered at E6+L: `done[i]`=1 for one cycle and `busy[i]`=0.
- General start-to-done latency: 2·(SYNC_STAGES+1)+L cycles plus any arbiter contention wait.
- The earliest re-accept of `start[i]` is on the edge after `done[i]` is high, i.e. when the FSM is IDLE.
- 4-phase rule: `req[i]` never rises again until `gsync[i]` has been observed low.

## Test plan
- Single channel: `start`=0001 and `hold_len`=4 at E0. Required: `req`=0001 after E0; `active[0]` high E3–E6; `req`=0000 after E7; `done[0]` pulse at E10; `mutex_err`=0.
- All channels at once: `start`=1111 and `hold_len`=3. Required: `req`=1111 after E0. `active` is one-hot at every cycle and each channel's `active` is high for exactly 3 cycles. All four `done` pulses occur; `mutex_err`=0.
- Zero length and maximum length: `hold_len`=0 → `active` high for exactly 1 cycle. `hold_len`=255 → `active` high for exactly 255 cycles, with no early release.
- Start while busy: `start[1]` pulsed again during REQ and during HOLD. Required: both pulses are ignored, exactly one `done[1]` is produced, and the length captured at the original start is used.
- Mutex violation: force `grant`=0011 for 1 cycle with no request. Required: `mutex_err`=1 after SYNC_STAGES+1 edges, and it remains 1 until `rst`.
- Reset in HOLD: assert `rst` for 1 cycle while channel 2 is active. Required: after that edge `req`, `busy` and `active` are 0000, `mutex_err`=0, and no `done` pulse occurs. A new `start[2]` then completes normally.

Source files
------------

// File: rtl/arb4_client.sv
// Requester front-end for the 4-input mutex arbiter: per-channel request FSMs
// with grant synchronizers, hold counters and a 4-phase release handshake.

module arb4_chan #(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [HOLD_W-1:0] hold_len,
  input  logic              grant,
  output logic              req,
  output logic              busy,
  output logic              active,
  output logic              done,
  output logic              gsync
);
  typedef enum logic [1:0] {IDLE, REQ, HOLD, RELEASE} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] gsync_pipe;
  logic [HOLD_W-1:0]      len, cnt;

  assign gsync = gsync_pipe[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (rst) gsync_pipe <= '0;
    else     gsync_pipe <= {gsync_pipe[SYNC_STAGES-2:0], grant};
  end

  // Outputs are registered alongside the state so they decode it exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len    <= '0;
      cnt    <= '0;
      req    <= 1'b0;
      busy   <= 1'b0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          len   <= hold_len;
          state <= REQ;
          req   <= 1'b1;
          busy  <= 1'b1;
        end
        REQ: if (gsync) begin
          cnt    <= (len == '0) ? HOLD_W'(1) : len;
          state  <= HOLD;
          active <= 1'b1;
        end
        HOLD: begin
          if (cnt == HOLD_W'(1)) begin
            state  <= RELEASE;
            req    <= 1'b0;
            active <= 1'b0;
          end else begin
            cnt <= cnt - HOLD_W'(1);
          end
        end
        RELEASE: if (!gsync) begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

module arb4_client #(
  parameter int NUM_REQ     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_W      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] start,
  input  logic [HOLD_W-1:0]  hold_len,
  output logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] grant,
  output logic [NUM_REQ-1:0] busy,
  output logic [NUM_REQ-1:0] active,
  output logic [NUM_REQ-1:0] done,
  output logic               mutex_err
);
  logic [NUM_REQ-1:0] gsync;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_chan
    arb4_chan #(.SYNC_STAGES(SYNC_STAGES), .HOLD_W(HOLD_W)) u_chan (
      .clk      (clk),
      .rst      (rst),
      .start    (start[i]),
      .hold_len (hold_len),
      .grant    (grant[i]),
      .req      (req[i]),
      .busy     (busy[i]),
      .active   (active[i]),
      .done     (done[i]),
      .gsync    (gsync[i])
    );
  end

  // More than one bit set <=> clearing the lowest set bit leaves something.
  always_ff @(posedge clk) begin
    if (rst)                                          mutex_err <= 1'b0;
    else if ((gsync & (gsync - NUM_REQ'(1))) != '0)   mutex_err <= 1'b1;
  end
endmodule

// File: tb/tb_arb4_client.sv
// Bench for arb4_client: zero-latency mutex arbiter model, cycle-level
// behavioural reference, directed scenarios and a randomized soak.

module tb_arb4_client;
  localparam int N  = 4;
  localparam int SS = 2;
  localparam int HW = 8;
  localparam int P_IDLE = 0, P_REQ = 1, P_HOLD = 2, P_REL = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  start = '0;
  logic [HW-1:0] hold_len = '0;
  logic [N-1:0]  req, grant, busy, active, done;
  logic          mutex_err;
  logic [N-1:0]  arb_grant = '0, force_grant = '0;

  assign grant = arb_grant | force_grant;
  always #5 clk = ~clk;

  arb4_client #(.NUM_REQ(N), .SYNC_STAGES(SS), .HOLD_W(HW)) dut (
    .clk(clk), .rst(rst), .start(start), .hold_len(hold_len), .req(req),
    .grant(grant), .busy(busy), .active(active), .done(done), .mutex_err(mutex_err)
  );

  int n_tests = 0, n_fail = 0, cyc = 0;

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Arbiter: grant held until the owner drops its request, lowest index wins.
  int owner = -1;
  always @(negedge clk) begin
    if (owner >= 0 && req[owner] !== 1'b1) owner = -1;
    if (owner < 0)
      for (int i = 0; i < N; i++) if (req[i] === 1'b1 && owner < 0) owner = i;
    arb_grant = (owner >= 0) ? (N'(1) << owner) : '0;
  end

  // Reference: gsync seen at an edge is the grant sampled SS edges earlier.
  int           ph[N], mlen[N], hold_end[N];
  logic [N-1:0] e_req = '0, e_busy = '0, e_active = '0, e_done = '0;
  logic         e_mutex = 1'b0;
  logic [N-1:0] gq[$];
  initial begin
    for (int i = 0; i < N; i++) ph[i] = P_IDLE;
    repeat (SS) gq.push_back('0);
  end

  always @(posedge clk) begin
    logic [N-1:0] seen;
    cyc++;
    seen = gq[0];
    if (rst) begin
      gq.delete();
      repeat (SS) gq.push_back('0);
      for (int i = 0; i < N; i++) ph[i] = P_IDLE;
      e_mutex = 1'b0;
      e_done  = '0;
    end else begin
      void'(gq.pop_front());
      gq.push_back(grant);
      if ($countones(seen) > 1) e_mutex = 1'b1;
      e_done = '0;
      for (int i = 0; i < N; i++) begin
        case (ph[i])
          P_IDLE: if (start[i]) begin mlen[i] = int'(hold_len); ph[i] = P_REQ; end
          P_REQ:  if (seen[i]) begin
                    hold_end[i] = cyc + ((mlen[i] == 0) ? 1 : mlen[i]);
                    ph[i] = P_HOLD;
                  end
          P_HOLD: if (cyc == hold_end[i]) ph[i] = P_REL;
          default: if (!seen[i]) begin ph[i] = P_IDLE; e_done[i] = 1'b1; end
        endcase
      end
    end
    for (int i = 0; i < N; i++) begin
      e_req[i]    = (ph[i] == P_REQ) || (ph[i] == P_HOLD);
      e_busy[i]   = (ph[i] != P_IDLE);
      e_active[i] = (ph[i] == P_HOLD);
    end
  end

  // Per-cycle comparison plus activity counters for the directed checks.
  int act_cnt[N], done_cnt[N], multi_act = 0;
  always begin
    @(posedge clk);
    #1;
    check("req",       32'(req),       32'(e_req));
    check("busy",      32'(busy),      32'(e_busy));
    check("active",    32'(active),    32'(e_active));
    check("done",      32'(done),      32'(e_done));
    check("mutex_err", 32'(mutex_err), 32'(e_mutex));
    for (int i = 0; i < N; i++) begin
      if (active[i] === 1'b1) act_cnt[i]++;
      if (done[i] === 1'b1)   done_cnt[i]++;
    end
    if ($countones(active) > 1) multi_act++;
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clr_cnt();
    for (int i = 0; i < N; i++) begin act_cnt[i] = 0; done_cnt[i] = 0; end
    multi_act = 0;
  endtask

  task automatic wait_idle(int budget);
    int k = 0;
    while (busy !== '0 && k < budget) begin @(negedge clk); k++; end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic go(logic [N-1:0] s, int len);
    start = s; hold_len = HW'(len);
    tick(1);
    start = '0;
  endtask

  initial begin
    tick(3);
    rst = 1'b0;
    check("reset_outs", 32'({req, busy, active, done, mutex_err}), 32'd0);

    // Single channel, length 4: timeline relative to the accepting edge E0.
    go(4'b0001, 4);
    check("single_req_e0", 32'(req), 32'b0001);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      check($sformatf("single_e%0d", k), 32'({req[0], active[0], done[0]}),
            32'({k <= 6, k >= 3 && k <= 6, k == 10}));
    end
    check("single_mutex", 32'(mutex_err), 32'd0);

    // All four at once.
    clr_cnt();
    go(4'b1111, 3);
    check("all_req_e0", 32'(req), 32'b1111);
    wait_idle(200);
    for (int i = 0; i < N; i++) begin
      check($sformatf("all_act%0d", i), act_cnt[i], 3);
      check($sformatf("all_done%0d", i), done_cnt[i], 1);
    end
    check("all_onehot", multi_act, 0);

    // Zero and maximum length.
    clr_cnt();
    go(4'b1000, 0);
    wait_idle(50);
    check("len0_act", act_cnt[3], 1);
    clr_cnt();
    go(4'b0010, 255);
    wait_idle(400);
    check("len255_act", act_cnt[1], 255);
    check("len255_done", done_cnt[1], 1);

    // Start while busy: re-pulses in REQ and in HOLD are ignored.
    clr_cnt();
    go(4'b0010, 5);
    go(4'b0010, 9);
    begin
      int k = 0;
      while (active[1] !== 1'b1 && k < 20) begin tick(1); k++; end
    end
    check("busy_wait_act", 32'(active[1]), 32'd1);
    go(4'b0010, 9);
    wait_idle(100);
    check("busy_act", act_cnt[1], 5);
    check("busy_done", done_cnt[1], 1);

    // Mutex violation from a forced two-hot grant with no request.
    force_grant = 4'b0011;
    tick(1);
    force_grant = '0;
    check("mutex_p1", 32'(mutex_err), 32'd0);
    tick(1);
    check("mutex_p2", 32'(mutex_err), 32'd0);
    tick(1);
    check("mutex_p3", 32'(mutex_err), 32'd1);
    tick(6);
    check("mutex_sticky", 32'(mutex_err), 32'd1);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mutex_rst", 32'(mutex_err), 32'd0);

    // Reset while channel 2 is in HOLD, then a clean rerun.
    go(4'b0100, 20);
    begin
      int k = 0;
      while (active[2] !== 1'b1 && k < 20) begin tick(1); k++; end
    end
    check("rsthold_wait_act", 32'(active[2]), 32'd1);
    tick(3);
    clr_cnt();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("rsthold_outs", 32'({req, busy, active, mutex_err}), 32'd0);
    tick(10);
    check("rsthold_nodone", done_cnt[2], 0);
    go(4'b0100, 2);
    wait_idle(60);
    check("rsthold_rerun_done", done_cnt[2], 1);
    check("rsthold_rerun_act", act_cnt[2], 2);

    // Randomized soak against the reference model.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) start[i] = ($urandom_range(0, 7) == 0);
      hold_len = ($urandom_range(0, 19) == 0) ? HW'(0) : HW'($urandom_range(1, 12));
      rst = ($urandom_range(0, 299) == 0);
      tick(1);
    end
    start = '0;
    rst = 1'b0;
    wait_idle(500);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
